// File: rtl/pixel_effect_pipe.sv
// Two-stage valid/ready colour-effect pipeline. Stage 1 reduces each effect to a per-channel
// signed numerator/divisor pair. Stage 2 divides, saturates and presents the result.
module pixel_effect_pipe #(
    parameter int CH_W   = 4,
    parameter int ADDR_W = 19
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [3*CH_W-1:0]   in_color,
    input  logic [3:0]          in_mode,
    input  logic [CH_W-1:0]     thresh,
    input  logic [CH_W:0]       bright,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [3*CH_W-1:0]   out_color
);

    localparam int PIX_W = 3 * CH_W;
    localparam int MAX   = (1 << CH_W) - 1;
    // Largest numerator is the sepia red sum (1351*MAX), plus a sign bit.
    localparam int NUM_W = CH_W + 12;
    localparam int DEN_W = (CH_W + 2 > 10) ? CH_W + 2 : 10;
    localparam logic signed [NUM_W-1:0] MAX_S = NUM_W'(MAX);

    typedef enum logic [3:0] {
        MODE_BYPASS = 4'b0001,
        MODE_GRAY   = 4'b0010,
        MODE_MELT   = 4'b0011,
        MODE_FREEZE = 4'b0100,
        MODE_SEPIA  = 4'b0101,
        MODE_INVERT = 4'b0110,
        MODE_BINAR  = 4'b0111,
        MODE_BRIGHT = 4'b1000
    } mode_t;

    logic                s1_valid_reg;
    logic [ADDR_W-1:0]   s1_addr_reg;
    logic                s2_valid_reg;
    logic [ADDR_W-1:0]   s2_addr_reg;
    logic [PIX_W-1:0]    s2_color_reg;
    logic [PIX_W-1:0]    s2_color_next;
    logic                s1_load;
    logic                s2_load;
    logic                s1_take;

    logic [CH_W-1:0]     chan [3];
    int                  luma_sum;
    int                  thresh_sum;
    int                  bright_val;

    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;
    assign s1_take  = s1_load && in_valid;

    assign out_valid = s2_valid_reg;
    assign out_addr  = s2_addr_reg;
    assign out_color = s2_color_reg;

    // Comparing the undivided luma sum against 100*thresh equals floor(Y) >= thresh.
    always_comb begin
        luma_sum   = 30 * int'(chan[0]) + 59 * int'(chan[1]) + 11 * int'(chan[2]);
        thresh_sum = 100 * int'(thresh);
        bright_val = int'($signed(bright));
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            localparam int O1    = (gi + 1) % 3;
            localparam int O2    = (gi + 2) % 3;
            localparam int SEP_R = (gi == 0) ? 393 : (gi == 1) ? 349 : 272;
            localparam int SEP_G = (gi == 0) ? 769 : (gi == 1) ? 686 : 534;
            localparam int SEP_B = (gi == 0) ? 189 : (gi == 1) ? 168 : 131;

            int                       c_val;
            int                       o1_val;
            int                       o2_val;
            int                       num_val;
            int                       den_val;
            logic signed [NUM_W-1:0]  num_reg;
            logic [DEN_W-1:0]         den_reg;
            logic signed [NUM_W-1:0]  quot;
            logic [CH_W-1:0]          sat;

            assign chan[gi] = in_color[(3-gi)*CH_W-1 -: CH_W];

            always_comb begin
                c_val   = int'(chan[gi]);
                o1_val  = int'(chan[O1]);
                o2_val  = int'(chan[O2]);
                num_val = c_val;
                den_val = 1;
                case (in_mode)
                    MODE_GRAY: begin
                        num_val = luma_sum;
                        den_val = 100;
                    end
                    MODE_MELT: begin
                        num_val = c_val * MAX;
                        den_val = o1_val + o2_val + 1;
                    end
                    MODE_FREEZE: begin
                        num_val = (c_val - o1_val - o2_val) * 3;
                        den_val = 2;
                    end
                    MODE_SEPIA: begin
                        num_val = SEP_R * int'(chan[0]) + SEP_G * int'(chan[1])
                                + SEP_B * int'(chan[2]);
                        den_val = 1000;
                    end
                    MODE_INVERT: num_val = MAX - c_val;
                    MODE_BINAR:  num_val = (luma_sum >= thresh_sum) ? MAX : 0;
                    MODE_BRIGHT: num_val = c_val + bright_val;
                    default:     num_val = c_val;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    num_reg <= '0;
                    den_reg <= DEN_W'(1);
                end else if (s1_take) begin
                    num_reg <= NUM_W'(num_val);
                    den_reg <= DEN_W'(den_val);
                end
            end

            // Signed division truncates toward zero, as freeze requires.
            assign quot = num_reg / $signed({{(NUM_W-DEN_W){1'b0}}, den_reg});

            always_comb begin
                if (quot < 0)
                    sat = '0;
                else if (quot > MAX_S)
                    sat = '1;
                else
                    sat = quot[CH_W-1:0];
            end

            assign s2_color_next[(3-gi)*CH_W-1 -: CH_W] = sat;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_addr_reg  <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid)
                s1_addr_reg <= in_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_addr_reg  <= '0;
            s2_color_reg <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_addr_reg  <= s1_addr_reg;
                s2_color_reg <= s2_color_next;
            end
        end
    end

endmodule
